// File: rtl/pipe_ctrl_pkg.sv
// Shared types and default stage layout for the pipeline controller.
// Optional perf counters in pipe_ctrl are enabled by defining PIPE_CTRL_PERF_EN.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH_REQ     = 2'd0,
        FETCH_WAIT    = 2'd1,
        FETCH_DISCARD = 2'd2
    } fetch_state_t;

    typedef enum logic {
        DBUS_IDLE = 1'b0,
        DBUS_WAIT = 1'b1
    } dbus_state_t;

    localparam int DEF_NUM_STAGES = 5;
    localparam int DEF_EX_STAGE   = 2;
    localparam int DEF_MEM_STAGE  = 3;
    localparam int DEF_CNT_W      = 32;

endpackage

// File: rtl/pipe_ctrl_fetch.sv
// Instruction-bus fetch FSM with redirect discard tracking and the one-entry skid flag.
module pipe_ctrl_fetch
    import pipe_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic addr_ok,
    input  logic data_ok,
    input  logic redirect,
    input  logic stall_one,
    output logic ireq_valid,
    output logic fetch_ok,
    output logic ibuf_we,
    output logic ibuf_valid
);

    fetch_state_t state_r, state_nxt_s;
    logic         pend_r, pend_nxt_s;
    logic         ibuf_valid_r, ibuf_valid_nxt_s;
    logic         ireq_s, fetch_ok_s, kill_s;

    // Next-state logic; pend_r remembers a redirect seen while the request was still unaccepted
    always_comb begin
        state_nxt_s = state_r;
        pend_nxt_s  = pend_r;
        ireq_s      = 1'b0;
        fetch_ok_s  = 1'b0;
        kill_s      = redirect | pend_r;
        case (state_r)
            FETCH_REQ: begin
                if (ibuf_valid_r) begin
                    pend_nxt_s = 1'b0;
                end else begin
                    ireq_s = 1'b1;
                    if (addr_ok) begin
                        pend_nxt_s = 1'b0;
                        if (data_ok) begin
                            fetch_ok_s = ~kill_s;
                        end else begin
                            state_nxt_s = kill_s ? FETCH_DISCARD : FETCH_WAIT;
                        end
                    end else if (redirect) begin
                        pend_nxt_s = 1'b1;
                    end else begin
                        pend_nxt_s = pend_r;
                    end
                end
            end
            FETCH_WAIT: begin
                if (data_ok) begin
                    fetch_ok_s  = ~redirect;
                    state_nxt_s = FETCH_REQ;
                end else if (redirect) begin
                    state_nxt_s = FETCH_DISCARD;
                end else begin
                    state_nxt_s = FETCH_WAIT;
                end
            end
            FETCH_DISCARD: begin
                if (data_ok) begin
                    state_nxt_s = FETCH_REQ;
                end else begin
                    state_nxt_s = FETCH_DISCARD;
                end
            end
            default: begin
                state_nxt_s = FETCH_REQ;
                pend_nxt_s  = 1'b0;
            end
        endcase
    end

    // Skid flag: set when a fetched word arrives behind a decode stall, dropped on consume or redirect
    always_comb begin
        if (redirect) begin
            ibuf_valid_nxt_s = 1'b0;
        end else if (fetch_ok_s & stall_one) begin
            ibuf_valid_nxt_s = 1'b1;
        end else if (~stall_one) begin
            ibuf_valid_nxt_s = 1'b0;
        end else begin
            ibuf_valid_nxt_s = ibuf_valid_r;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= FETCH_REQ;
            pend_r       <= 1'b0;
            ibuf_valid_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            pend_r       <= pend_nxt_s;
            ibuf_valid_r <= ibuf_valid_nxt_s;
        end
    end

    assign ireq_valid = ireq_s & ~reset;
    assign fetch_ok   = fetch_ok_s & ~reset;
    assign ibuf_we    = fetch_ok & stall_one;
    assign ibuf_valid = ibuf_valid_r;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline controller: dbus handshake FSM and per-stage stall/flush composition.
// Define PIPE_CTRL_PERF_EN to build the stall/redirect performance counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = DEF_NUM_STAGES,
    parameter int EX_STAGE   = DEF_EX_STAGE,
    parameter int MEM_STAGE  = DEF_MEM_STAGE,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ireq_valid,
    input  logic                  iresp_addr_ok,
    input  logic                  iresp_data_ok,
    output logic                  dreq_valid,
    input  logic                  mem_op,
    input  logic                  dresp_addr_ok,
    input  logic                  dresp_data_ok,
    input  logic                  load_use,
    input  logic                  redirect,
    output logic                  pc_en,
    output logic                  ibuf_we,
    output logic                  ibuf_valid,
    output logic [NUM_STAGES-1:0] stall,
    output logic [NUM_STAGES-1:0] flush,
    output logic [CNT_W-1:0]      perf_stall,
    output logic [CNT_W-1:0]      perf_flush
);

    dbus_state_t           dstate_r, dstate_nxt_s;
    logic                  dreq_s, done_s, mem_wait_s, redirect_taken_s, stall_one_s, fetch_ok_s;
    logic [NUM_STAGES-1:0] stall_s, flush_s;

    // dbus handshake; done can complete in the same cycle the address is accepted
    always_comb begin
        dstate_nxt_s = dstate_r;
        dreq_s       = 1'b0;
        done_s       = 1'b0;
        case (dstate_r)
            DBUS_IDLE: begin
                if (mem_op) begin
                    dreq_s = 1'b1;
                    if (dresp_addr_ok & dresp_data_ok) begin
                        done_s = 1'b1;
                    end else if (dresp_addr_ok) begin
                        dstate_nxt_s = DBUS_WAIT;
                    end else begin
                        dstate_nxt_s = DBUS_IDLE;
                    end
                end else begin
                    dstate_nxt_s = DBUS_IDLE;
                end
            end
            DBUS_WAIT: begin
                if (dresp_data_ok) begin
                    done_s       = 1'b1;
                    dstate_nxt_s = DBUS_IDLE;
                end else begin
                    dstate_nxt_s = DBUS_WAIT;
                end
            end
            default: dstate_nxt_s = DBUS_IDLE;
        endcase
    end

    // dbus state register
    always_ff @(posedge clk) begin
        if (reset) begin
            dstate_r <= DBUS_IDLE;
        end else begin
            dstate_r <= dstate_nxt_s;
        end
    end

    assign dreq_valid       = dreq_s & ~reset;
    assign mem_wait_s       = mem_op & ~done_s & ~reset;
    assign redirect_taken_s = redirect & ~mem_wait_s & ~reset;
    // Decode-register hold without the fetch term, so the skid logic sees no loop through fetch_ok
    assign stall_one_s      = mem_wait_s | (~redirect_taken_s & load_use & (EX_STAGE > 1));

    pipe_ctrl_fetch u_fetch (
        .clk        (clk),
        .reset      (reset),
        .addr_ok    (iresp_addr_ok),
        .data_ok    (iresp_data_ok),
        .redirect   (redirect_taken_s),
        .stall_one  (stall_one_s),
        .ireq_valid (ireq_valid),
        .fetch_ok   (fetch_ok_s),
        .ibuf_we    (ibuf_we),
        .ibuf_valid (ibuf_valid)
    );

    // Stall/flush priority: memory wait, then redirect, then load-use, then front-end wait
    always_comb begin
        stall_s = '0;
        flush_s = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (reset) begin
                stall_s[i] = 1'b0;
            end else if (mem_wait_s) begin
                stall_s[i] = (i <= MEM_STAGE);
                flush_s[i] = (i == MEM_STAGE + 1);
            end else if (redirect_taken_s) begin
                flush_s[i] = (i >= 1) && (i <= EX_STAGE);
            end else if (load_use) begin
                stall_s[i] = (i < EX_STAGE);
                flush_s[i] = (i == EX_STAGE);
            end else if (~fetch_ok_s & ~ibuf_valid) begin
                stall_s[i] = (i == 0);
                flush_s[i] = (i == 1);
            end else begin
                stall_s[i] = 1'b0;
            end
        end
    end

    assign stall = stall_s;
    assign flush = flush_s;
    assign pc_en = ~reset & ((((fetch_ok_s | ibuf_valid) & ~stall_s[1])) | redirect_taken_s);

`ifdef PIPE_CTRL_PERF_EN
    logic [CNT_W-1:0] perf_stall_r, perf_flush_r;

    // Free-running wrap-around event counters
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_stall_r <= '0;
            perf_flush_r <= '0;
        end else begin
            if (|stall_s) begin
                perf_stall_r <= perf_stall_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (redirect_taken_s) begin
                perf_flush_r <= perf_flush_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign perf_stall = perf_stall_r;
    assign perf_flush = perf_flush_r;
`else
    assign perf_stall = '0;
    assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl with the default 5-stage layout.
module tb_pipe_ctrl;
    import pipe_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ireq_valid, iresp_addr_ok, iresp_data_ok;
    logic        dreq_valid, mem_op, dresp_addr_ok, dresp_data_ok;
    logic        load_use, redirect;
    logic        pc_en, ibuf_we, ibuf_valid;
    logic [4:0]  stall, flush;
    logic [31:0] perf_stall, perf_flush;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ps   = 0;
    int exp_pf   = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .ireq_valid    (ireq_valid),
        .iresp_addr_ok (iresp_addr_ok),
        .iresp_data_ok (iresp_data_ok),
        .dreq_valid    (dreq_valid),
        .mem_op        (mem_op),
        .dresp_addr_ok (dresp_addr_ok),
        .dresp_data_ok (dresp_data_ok),
        .load_use      (load_use),
        .redirect      (redirect),
        .pc_en         (pc_en),
        .ibuf_we       (ibuf_we),
        .ibuf_valid    (ibuf_valid),
        .stall         (stall),
        .flush         (flush),
        .perf_stall    (perf_stall),
        .perf_flush    (perf_flush)
    );

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // in_v = {iaddr_ok, idata_ok, mem_op, daddr_ok, ddata_ok, load_use, redirect}
    task automatic step(input string tag, input logic [6:0] in_v,
                        input logic [4:0] e_stall, input logic [4:0] e_flush,
                        input logic e_pc, input logic e_ireq, input logic e_dreq,
                        input logic e_ibv, input logic e_ibwe);
        @(negedge clk);
        {iresp_addr_ok, iresp_data_ok, mem_op, dresp_addr_ok, dresp_data_ok, load_use, redirect} = in_v;
        #1;
        check_eq({tag, ".stall"}, 64'(stall), 64'(e_stall));
        check_eq({tag, ".flush"}, 64'(flush), 64'(e_flush));
        check_eq({tag, ".pc_en"}, 64'(pc_en), 64'(e_pc));
        check_eq({tag, ".ireq"},  64'(ireq_valid), 64'(e_ireq));
        check_eq({tag, ".dreq"},  64'(dreq_valid), 64'(e_dreq));
        check_eq({tag, ".ibv"},   64'(ibuf_valid), 64'(e_ibv));
        check_eq({tag, ".ibwe"},  64'(ibuf_we), 64'(e_ibwe));
        check_eq({tag, ".pstall"}, 64'(perf_stall), 64'(exp_ps));
        check_eq({tag, ".pflush"}, 64'(perf_flush), 64'(exp_pf));
`ifdef PIPE_CTRL_PERF_EN
        if (e_stall != 5'd0) exp_ps++;
        if (e_pc && (e_flush == 5'b00110)) exp_pf++;
`endif
    endtask

    task automatic do_reset(input logic hold_mem);
        @(negedge clk);
        reset = 1'b1;
        {iresp_addr_ok, iresp_data_ok, dresp_addr_ok, dresp_data_ok, load_use, redirect} = 6'd0;
        mem_op = hold_mem;
        #1;
        check_eq("rst.stall", 64'(stall), 64'd0);
        check_eq("rst.flush", 64'(flush), 64'd0);
        check_eq("rst.pc_en", 64'(pc_en), 64'd0);
        check_eq("rst.dreq",  64'(dreq_valid), 64'd0);
        @(negedge clk);
        reset  = 1'b0;
        mem_op = 1'b0;
        exp_ps = 0;
        exp_pf = 0;
    endtask

    initial begin
        reset = 1'b1;
        {iresp_addr_ok, iresp_data_ok, mem_op, dresp_addr_ok, dresp_data_ok, load_use, redirect} = 7'd0;
        do_reset(1'b0);

        //        tag         in_v        stall     flush     pc    ireq  dreq  ibv   ibwe
        step("idle",     7'b0000000, 5'b00001, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++)
            step("zw",   7'b1100000, 5'b00000, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("mw0",      7'b1110000, 5'b01111, 5'b10000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("mw1",      7'b1111000, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step("mw2",      7'b0010000, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mw3",      7'b0010000, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step("mwdone",   7'b0010100, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("resume",   7'b1100000, 5'b00000, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("lu",       7'b1100010, 5'b00011, 5'b00100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        step("lu_rel",   7'b0000000, 5'b00000, 5'b00000, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        step("fw",       7'b1000000, 5'b00001, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rdwait",   7'b0000001, 5'b00000, 5'b00110, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        step("drop",     7'b0100000, 5'b00001, 5'b00010, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        step("refetch",  7'b1100000, 5'b00000, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rdmw",     7'b1110001, 5'b01111, 5'b10000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("rddone",   7'b0011101, 5'b00000, 5'b00110, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        step("post",     7'b1100000, 5'b00000, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step("dw0",      7'b1111000, 5'b01111, 5'b10000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        step("dw1",      7'b0010000, 5'b01111, 5'b10000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        do_reset(1'b1);
        step("rst_rel",  7'b0000000, 5'b00001, 5'b00010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        step("rst_dbus", 7'b1111100, 5'b00000, 5'b00000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step("tail",     7'b1100000, 5'b00000, 5'b00000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
